// File: rtl/muldiv_unit.sv
// Iterative 8-bit multiply/divide unit: 8 shift-add or restoring-division steps, then a one-cycle register-file write.
// Optional divider hardware is built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int pw = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [7:0]    dat_a,
  input  logic [7:0]    dat_b,
  input  logic [pw:0]   dst_addr,
  output logic          busy,
  output logic          done,
  output logic          wr_en,
  output logic [pw:0]   wr_addr,
  output logic [7:0]    dat_out,
  output logic          div_zero
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t       state_q;
  logic [2:0]   cnt_q;
  logic [1:0]   op_q;
  logic [pw:0]  dst_q;
  logic [15:0]  prod_q, prod_d;
  logic [15:0]  mcand_q;
  logic [7:0]   mplier_q;
  logic         done_q, wr_en_q, div_zero_q;
  logic [pw:0]  wr_addr_q;
  logic [7:0]   dat_out_q;
  logic [7:0]   result_d;

`ifdef MULDIV_DIV_EN
  logic [7:0]   quo_q, quo_d;
  logic [7:0]   divisor_q;
  logic [8:0]   rem_q, rem_d;
  logic [8:0]   shifted;
  logic [9:0]   diff;
  logic         dz_q;

  // Restoring step: the dividend is shifted out of the quotient register MSB-first.
  // A zero divisor always "fits", giving quotient 8'hFF and remainder equal to the dividend.
  always_comb begin
    shifted = {rem_q[7:0], quo_q[7]};
    diff    = {1'b0, shifted} - {2'b00, divisor_q};
    rem_d   = shifted;
    quo_d   = {quo_q[6:0], 1'b0};
    if (!diff[9]) begin
      rem_d = diff[8:0];
      quo_d = {quo_q[6:0], 1'b1};
    end
  end
`endif

  always_comb begin
    prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  end

  always_comb begin
    result_d = 8'h00;
    case (op_q)
      2'b00:   result_d = prod_d[7:0];
      2'b01:   result_d = prod_d[15:8];
`ifdef MULDIV_DIV_EN
      2'b10:   result_d = quo_d;
      default: result_d = rem_d[7:0];
`else
      default: result_d = 8'h00;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      op_q       <= 2'b00;
      dst_q      <= '0;
      prod_q     <= 16'h0000;
      mcand_q    <= 16'h0000;
      mplier_q   <= 8'h00;
`ifdef MULDIV_DIV_EN
      quo_q      <= 8'h00;
      rem_q      <= 9'h000;
      divisor_q  <= 8'h00;
      dz_q       <= 1'b0;
`endif
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      dat_out_q  <= 8'h00;
      div_zero_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[7:1]};
`ifdef MULDIV_DIV_EN
          quo_q    <= quo_d;
          rem_q    <= rem_d;
`endif
          if (cnt_q == 3'd0) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            dat_out_q <= result_d;
            wr_addr_q <= dst_q;
`ifdef MULDIV_DIV_EN
            wr_en_q    <= 1'b1;
            div_zero_q <= op_q[1] & dz_q;
`else
            // Divide ops complete without a write when no divider is built.
            wr_en_q    <= ~op_q[1];
            div_zero_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          if (start) begin
            state_q   <= ST_RUN;
            cnt_q     <= 3'd7;
            op_q      <= op;
            dst_q     <= dst_addr;
            prod_q    <= 16'h0000;
            mcand_q   <= {8'h00, dat_a};
            mplier_q  <= dat_b;
`ifdef MULDIV_DIV_EN
            quo_q     <= dat_a;
            rem_q     <= 9'h000;
            divisor_q <= dat_b;
            dz_q      <= (dat_b == 8'h00);
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign dat_out  = dat_out_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected write requests are queued at start and compared at done.
module tb_muldiv_unit;

  localparam int PW = 4;

  typedef struct packed {
    logic [7:0]  dat;
    logic [PW:0] addr;
    logic        dz;
    logic        wr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [7:0]    dat_a = 8'h00;
  logic [7:0]    dat_b = 8'h00;
  logic [PW:0]   dst_addr = '0;
  logic          busy, done, wr_en, div_zero;
  logic [PW:0]   wr_addr;
  logic [7:0]    dat_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int start_cyc = 0;
  exp_t sb_q[$];

  muldiv_unit #(.pw(PW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .dat_a(dat_a), .dat_b(dat_b), .dst_addr(dst_addr),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
    .dat_out(dat_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (wr_en === 1'b1) wr_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic exp_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic [PW:0] d);
    exp_t m;
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    m.addr = d;
    m.wr = 1'b1;
    m.dz = 1'b0;
    m.dat = 8'h00;
    case (o)
      2'b00: m.dat = p[7:0];
      2'b01: m.dat = p[15:8];
      2'b10: begin m.dz = (b == 8'h00); m.dat = (b == 8'h00) ? 8'hFF : 8'(a / b); end
      default: begin m.dz = (b == 8'h00); m.dat = (b == 8'h00) ? a : 8'(a % b); end
    endcase
`ifndef MULDIV_DIV_EN
    if (o[1]) begin
      m.dat = 8'h00;
      m.wr = 1'b0;
      m.dz = 1'b0;
    end
`endif
    return m;
  endfunction

  // Drives a one-cycle start from the current time; returns 1 time unit after the sampling edge.
  task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [PW:0] d, input bit push);
    start = 1'b1; op = o; dat_a = a; dat_b = b; dst_addr = d;
    if (push) sb_q.push_back(model(o, a, b, d));
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, wr_en, wr_addr, dat_out, div_zero} !== '0) begin
      failures++;
      $display("FAIL reset_values: got busy=%b done=%b wr_en=%b wr_addr=%0d dat_out=%h div_zero=%b, need all 0",
               busy, done, wr_en, wr_addr, dat_out, div_zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul;
    logic [7:0] ta[2] = '{8'd13, 8'd200};
    logic [7:0] tb[2] = '{8'd11, 8'd200};
    logic [1:0] to[2] = '{2'b00, 2'b01};
    logic [PW:0] td[2] = '{5'd3, 5'd5};
    int dc;
    exp_t e, g;
    for (int i = 0; i < 2; i++) begin
      issue(to[i], ta[i], tb[i], td[i], 1'b1);
      wait_done(dc);
      checks++;
      if (dc - start_cyc !== 8) begin
        failures++;
        $display("FAIL mul_latency[%0d]: got %0d cycles, need 8", i, dc - start_cyc);
      end
      e = sb_q.pop_front();
      g = {dat_out, wr_addr, div_zero, wr_en};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL mul_result[%0d]: got dat=%h addr=%0d dz=%b wr=%b, need dat=%h addr=%0d dz=%b wr=%b",
                 i, g.dat, g.addr, g.dz, g.wr, e.dat, e.addr, e.dz, e.wr);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({done, wr_en} !== 2'b00) begin
        failures++;
        $display("FAIL mul_strobe_width[%0d]: got done=%b wr_en=%b after one cycle, need 0 0", i, done, wr_en);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, dat_out, wr_addr, div_zero} !== {1'b0, e.dat, e.addr, e.dz}) begin
        failures++;
        $display("FAIL mul_hold[%0d]: got busy=%b dat=%h addr=%0d dz=%b, need busy=0 dat=%h addr=%0d dz=%b",
                 i, busy, dat_out, wr_addr, div_zero, e.dat, e.addr, e.dz);
      end
    end
  endtask

  task automatic test_div;
    logic [7:0] ta[4] = '{8'd200, 8'd200, 8'h55, 8'h55};
    logic [7:0] tb[4] = '{8'd7, 8'd7, 8'h00, 8'h00};
    logic [1:0] to[4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    int dc;
    exp_t e, g;
    for (int i = 0; i < 4; i++) begin
      issue(to[i], ta[i], tb[i], 5'(i + 8), 1'b1);
      wait_done(dc);
      checks++;
      if (dc - start_cyc !== 8) begin
        failures++;
        $display("FAIL div_latency[%0d]: got %0d cycles, need 8", i, dc - start_cyc);
      end
      e = sb_q.pop_front();
      g = {dat_out, wr_addr, div_zero, wr_en};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL div_result[%0d]: got dat=%h addr=%0d dz=%b wr=%b, need dat=%h addr=%0d dz=%b wr=%b",
                 i, g.dat, g.addr, g.dz, g.wr, e.dat, e.addr, e.dz, e.wr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_start_ignored;
    int dc, w0;
    exp_t e, g;
    w0 = wr_pulses;
    issue(2'b00, 8'd13, 8'd11, 5'd7, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; dat_a = 8'hFF; dat_b = 8'hFF; dst_addr = 5'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(dc);
    checks++;
    if (dc - start_cyc !== 8) begin
      failures++;
      $display("FAIL ignore_latency: got %0d cycles, need 8", dc - start_cyc);
    end
    e = sb_q.pop_front();
    g = {dat_out, wr_addr, div_zero, wr_en};
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL ignore_result: got dat=%h addr=%0d dz=%b wr=%b, need dat=%h addr=%0d dz=%b wr=%b",
               g.dat, g.addr, g.dz, g.wr, e.dat, e.addr, e.dz, e.wr);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (wr_pulses - w0 !== 1) begin
      failures++;
      $display("FAIL ignore_pulses: got %0d wr_en pulses, need 1", wr_pulses - w0);
    end
  endtask

  task automatic test_back_to_back;
    int dc1, dc2;
    exp_t e, g;
    issue(2'b00, 8'd9, 8'd9, 5'd10, 1'b1);
    wait_done(dc1);
    e = sb_q.pop_front();
    g = {dat_out, wr_addr, div_zero, wr_en};
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL b2b_first: got dat=%h addr=%0d dz=%b wr=%b, need dat=%h addr=%0d dz=%b wr=%b",
               g.dat, g.addr, g.dz, g.wr, e.dat, e.addr, e.dz, e.wr);
    end
    issue(2'b00, 8'd2, 8'd3, 5'd11, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_busy: got busy=%b after back-to-back start, need 1", busy);
    end
    wait_done(dc2);
    checks++;
    if (dc2 - dc1 !== 9) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d cycles between done strobes, need 9", dc2 - dc1);
    end
    e = sb_q.pop_front();
    g = {dat_out, wr_addr, div_zero, wr_en};
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL b2b_second: got dat=%h addr=%0d dz=%b wr=%b, need dat=%h addr=%0d dz=%b wr=%b",
               g.dat, g.addr, g.dz, g.wr, e.dat, e.addr, e.dz, e.wr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run;
    int dc, w0;
    exp_t e, g;
    w0 = wr_pulses;
    issue(2'b01, 8'hF0, 8'hF0, 5'd21, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, wr_en, wr_addr, dat_out, div_zero} !== '0) begin
      failures++;
      $display("FAIL midrun_reset: got busy=%b done=%b wr_en=%b wr_addr=%0d dat_out=%h div_zero=%b, need all 0",
               busy, done, wr_en, wr_addr, dat_out, div_zero);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (wr_pulses - w0 !== 0) begin
      failures++;
      $display("FAIL midrun_no_write: got %0d wr_en pulses, need 0", wr_pulses - w0);
    end
    issue(2'b00, 8'd25, 8'd5, 5'd12, 1'b1);
    wait_done(dc);
    checks++;
    if (dc - start_cyc !== 8) begin
      failures++;
      $display("FAIL post_reset_latency: got %0d cycles, need 8", dc - start_cyc);
    end
    e = sb_q.pop_front();
    g = {dat_out, wr_addr, div_zero, wr_en};
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL post_reset_result: got dat=%h addr=%0d dz=%b wr=%b, need dat=%h addr=%0d dz=%b wr=%b",
               g.dat, g.addr, g.dz, g.wr, e.dat, e.addr, e.dz, e.wr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    int dc;
    exp_t e, g;
    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(3)), 8'($urandom), 8'($urandom), 5'($urandom), 1'b1);
      wait_done(dc);
      e = sb_q.pop_front();
      g = {dat_out, wr_addr, div_zero, wr_en};
      checks++;
      if (g !== e || dc - start_cyc !== 8) begin
        failures++;
        $display("FAIL random[%0d]: got dat=%h addr=%0d dz=%b wr=%b lat=%0d, need dat=%h addr=%0d dz=%b wr=%b lat=8",
                 i, g.dat, g.addr, g.dz, g.wr, dc - start_cyc, e.dat, e.addr, e.dz, e.wr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
